parser_rule_cfg: RTL

- Next-generation rule/offset configuration block for the multi-stage programmable parser.
- Serves STAGE_NUM parser stages from one 64-bit config bus with a valid/ready handshake.
- Rule fields are written into per-stage staging registers. A commit command later pushes them to one stage's rule table atomically through a 3-state sequencer.
- Registers can be read back.

---
 rtl/parser_cfg_pkg.sv | 40 ++++
 rtl/parser_cfg_stage_bank.sv | 98 +++++++++
 rtl/parser_rule_cfg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/parser_cfg_pkg.sv
// rtl/parser_cfg_pkg.sv - shared types and address layout for the parser rule config block
package parser_cfg_pkg;

  localparam int CFG_TYPE_NUM         = 4;
  localparam int CFG_TYPE_WIDTH       = 8;
  localparam int CFG_KEY_OFFSET_WIDTH = 6;
  localparam int CFG_KEY_FIELD_NUM    = 8;

  localparam int ADDR_STAGE_LSB  = 16;
  localparam int ADDR_REGION_LSB = 12;
  localparam int ADDR_INDEX_LSB  = 0;
  localparam int ADDR_STAGE_W    = 4;
  localparam int ADDR_REGION_W   = 4;
  localparam int ADDR_INDEX_W    = 6;

  localparam int WDATA_TYPE_DATA_LSB = 32;
  localparam int STATUS_ERR_LSB      = 16;

  typedef enum logic [3:0] {
    REG_TYPE_OFF  = 4'd0,
    REG_TYPE_DATA = 4'd1,
    REG_KEY_OFF   = 4'd2,
    REG_COMMIT    = 4'd3,
    REG_STATUS    = 4'd4
  } region_e;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SETUP  = 2'd1,
    SEQ_STROBE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic                                         valid;
    logic [CFG_TYPE_NUM*CFG_TYPE_WIDTH-1:0]       type_data;
    logic [CFG_TYPE_NUM*CFG_TYPE_WIDTH-1:0]       type_mask;
    logic [CFG_KEY_FIELD_NUM*CFG_KEY_OFFSET_WIDTH-1:0] key_offset;
  } rule_t;

endpackage

// File: rtl/parser_cfg_stage_bank.sv
// rtl/parser_cfg_stage_bank.sv - one stage's live type offsets, staged rule fields and read mux
// Read mux is built only when PARSER_CFG_READBACK_EN is defined.
module parser_cfg_stage_bank
  import parser_cfg_pkg::*;
#(
  parameter int TYPE_OFFSET_WIDTH = 7,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 8,
  parameter int KEY_OFFSET_WIDTH  = 6,
  parameter int KEY_FIELD_NUM     = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       wr_en_i,
  input  region_e                                    region_i,
  input  logic [ADDR_INDEX_W-1:0]                    index_i,
  input  logic [63:0]                                wdata_i,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]      type_offset_o,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]             type_data_o,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]             type_mask_o,
  output logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0]  key_offset_o,
  output logic [63:0]                                rdata_o
);

  logic [TYPE_OFFSET_WIDTH-1:0] type_off_q  [TYPE_NUM];
  logic [TYPE_WIDTH-1:0]        type_data_q [TYPE_NUM];
  logic [TYPE_WIDTH-1:0]        type_mask_q [TYPE_NUM];
  logic [KEY_OFFSET_WIDTH-1:0]  key_off_q   [KEY_FIELD_NUM];
  logic                         unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TYPE_NUM; i++) begin
        type_off_q[i]  <= '0;
        type_data_q[i] <= '0;
        type_mask_q[i] <= '0;
      end
      for (int k = 0; k < KEY_FIELD_NUM; k++) begin
        key_off_q[k] <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < TYPE_NUM; i++) begin
        if (index_i == ADDR_INDEX_W'(i)) begin
          if (region_i == REG_TYPE_OFF) begin
            type_off_q[i] <= wdata_i[TYPE_OFFSET_WIDTH-1:0];
          end
          if (region_i == REG_TYPE_DATA) begin
            type_data_q[i] <= wdata_i[WDATA_TYPE_DATA_LSB +: TYPE_WIDTH];
            type_mask_q[i] <= wdata_i[0 +: TYPE_WIDTH];
          end
        end
      end
      for (int k = 0; k < KEY_FIELD_NUM; k++) begin
        if (region_i == REG_KEY_OFF && index_i == ADDR_INDEX_W'(k)) begin
          key_off_q[k] <= wdata_i[0 +: KEY_OFFSET_WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < TYPE_NUM; g++) begin : g_type
    assign type_offset_o[g*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH] = type_off_q[g];
    assign type_data_o[g*TYPE_WIDTH +: TYPE_WIDTH]                 = type_data_q[g];
    assign type_mask_o[g*TYPE_WIDTH +: TYPE_WIDTH]                 = type_mask_q[g];
  end

  for (genvar g = 0; g < KEY_FIELD_NUM; g++) begin : g_key
    assign key_offset_o[g*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH] = key_off_q[g];
  end

`ifdef PARSER_CFG_READBACK_EN
  // Each field is returned in the same bit position it was written from.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < TYPE_NUM; i++) begin
      if (index_i == ADDR_INDEX_W'(i)) begin
        if (region_i == REG_TYPE_OFF) begin
          rdata_o[TYPE_OFFSET_WIDTH-1:0] = type_off_q[i];
        end
        if (region_i == REG_TYPE_DATA) begin
          rdata_o[WDATA_TYPE_DATA_LSB +: TYPE_WIDTH] = type_data_q[i];
          rdata_o[0 +: TYPE_WIDTH]                   = type_mask_q[i];
        end
      end
    end
    for (int k = 0; k < KEY_FIELD_NUM; k++) begin
      if (region_i == REG_KEY_OFF && index_i == ADDR_INDEX_W'(k)) begin
        rdata_o[0 +: KEY_OFFSET_WIDTH] = key_off_q[k];
      end
    end
  end
`else
  assign rdata_o = '0;
`endif

endmodule

// File: rtl/parser_rule_cfg.sv
// rtl/parser_rule_cfg.sv - config bus front end, commit sequencer and rule output bus
// Register readback of regions 0-2 requires PARSER_CFG_READBACK_EN.
module parser_rule_cfg
  import parser_cfg_pkg::*;
#(
  parameter int STAGE_NUM         = 3,
  parameter int TYPE_OFFSET_WIDTH = 7,
  parameter int TYPE_NUM          = CFG_TYPE_NUM,
  parameter int TYPE_WIDTH        = CFG_TYPE_WIDTH,
  parameter int KEY_OFFSET_WIDTH  = CFG_KEY_OFFSET_WIDTH,
  parameter int KEY_FIELD_NUM     = CFG_KEY_FIELD_NUM,
  parameter int RULE_NUM          = 16
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst_n,
  input  logic                                              i_cfg_valid,
  input  logic                                              i_cfg_wr,
  input  logic [31:0]                                       i_cfg_addr,
  input  logic [63:0]                                       i_cfg_wdata,
  output logic                                              o_cfg_ready,
  output logic                                              o_cfg_rvalid,
  output logic [63:0]                                       o_cfg_rdata,
  output logic [STAGE_NUM*TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]   o_type_offset,
  output logic [STAGE_NUM*RULE_NUM-1:0]                     o_rule_wren,
  output logic                                              o_rule_valid,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]                    o_rule_typeData,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]                    o_rule_typeMask,
  output logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0]         o_rule_keyOffset,
  output logic [15:0]                                       o_err_cnt
);

  localparam int TO_BANK_W = TYPE_NUM*TYPE_OFFSET_WIDTH;

  logic [ADDR_STAGE_W-1:0]  req_stage;
  logic [ADDR_REGION_W-1:0] req_region_raw;
  region_e                  req_region;
  logic [ADDR_INDEX_W-1:0]  req_index;
  logic                     unused_addr;

  logic accept, reject, idx_ok, good, commit_go;

  seq_state_e state_q, state_d;
  rule_t      rule_q, rule_d;
  logic [ADDR_STAGE_W-1:0] commit_stage_q;
  logic [ADDR_INDEX_W-1:0] commit_id_q;
  logic [15:0] err_cnt_q;
  logic        rvalid_q;
  logic [63:0] rdata_q, rdata_d;

  logic [STAGE_NUM-1:0]                        bank_wr;
  logic [TYPE_NUM*TYPE_WIDTH-1:0]              bank_td   [STAGE_NUM];
  logic [TYPE_NUM*TYPE_WIDTH-1:0]              bank_tm   [STAGE_NUM];
  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0]   bank_key  [STAGE_NUM];
  logic [63:0]                                 bank_rdata[STAGE_NUM];

  assign req_stage      = i_cfg_addr[ADDR_STAGE_LSB +: ADDR_STAGE_W];
  assign req_region_raw = i_cfg_addr[ADDR_REGION_LSB +: ADDR_REGION_W];
  assign req_region     = region_e'(req_region_raw);
  assign req_index      = i_cfg_addr[ADDR_INDEX_LSB +: ADDR_INDEX_W];
  assign unused_addr    = ^{i_cfg_addr[31:20], i_cfg_addr[11:6]};

  // Status is a single register, so only index 0 is a legal address there.
  always_comb begin
    idx_ok = 1'b0;
    case (req_region_raw)
      4'd0, 4'd1: idx_ok = {1'b0, req_index} < 7'(TYPE_NUM);
      4'd2:       idx_ok = {1'b0, req_index} < 7'(KEY_FIELD_NUM);
      4'd3:       idx_ok = {1'b0, req_index} < 7'(RULE_NUM);
      4'd4:       idx_ok = (req_index == '0);
      default:    idx_ok = 1'b0;
    endcase
  end

  assign accept    = i_cfg_valid && o_cfg_ready;
  assign reject    = ({1'b0, req_stage} >= 5'(STAGE_NUM)) || !idx_ok ||
                     (req_region_raw == 4'd4 && i_cfg_wr);
  assign good      = accept && !reject;
  assign commit_go = good && i_cfg_wr && (req_region_raw == 4'd3);

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    assign bank_wr[s] = good && i_cfg_wr && (req_stage == ADDR_STAGE_W'(s)) &&
                        (req_region_raw <= 4'd2);

    parser_cfg_stage_bank #(
      .TYPE_OFFSET_WIDTH (TYPE_OFFSET_WIDTH),
      .TYPE_NUM          (TYPE_NUM),
      .TYPE_WIDTH        (TYPE_WIDTH),
      .KEY_OFFSET_WIDTH  (KEY_OFFSET_WIDTH),
      .KEY_FIELD_NUM     (KEY_FIELD_NUM)
    ) u_bank (
      .clk_i         (i_clk),
      .rst_ni        (i_rst_n),
      .wr_en_i       (bank_wr[s]),
      .region_i      (req_region),
      .index_i       (req_index),
      .wdata_i       (i_cfg_wdata),
      .type_offset_o (o_type_offset[s*TO_BANK_W +: TO_BANK_W]),
      .type_data_o   (bank_td[s]),
      .type_mask_o   (bank_tm[s]),
      .key_offset_o  (bank_key[s]),
      .rdata_o       (bank_rdata[s])
    );
  end

  always_comb begin
    state_d     = state_q;
    o_cfg_ready = (state_q == SEQ_IDLE);
    o_rule_wren = '0;
    case (state_q)
      SEQ_IDLE:   if (commit_go) state_d = SEQ_SETUP;
      SEQ_SETUP:  state_d = SEQ_STROBE;
      SEQ_STROBE: state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        o_rule_wren[s*RULE_NUM + r] = (state_q == SEQ_STROBE) &&
                                      (commit_stage_q == ADDR_STAGE_W'(s)) &&
                                      (commit_id_q == ADDR_INDEX_W'(r));
      end
    end
  end

  // The bus is captured on the commit handshake so it is stable through SETUP and STROBE.
  always_comb begin
    rule_d = rule_q;
    if (commit_go) begin
      rule_d.valid = i_cfg_wdata[0];
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (req_stage == ADDR_STAGE_W'(s)) begin
          rule_d.type_data  = bank_td[s];
          rule_d.type_mask  = bank_tm[s];
          rule_d.key_offset = bank_key[s];
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (accept && !i_cfg_wr && !reject) begin
      if (req_region_raw == 4'd4) begin
        rdata_d[STATUS_ERR_LSB +: 16] = err_cnt_q;
        rdata_d[0]                    = (state_q != SEQ_IDLE);
      end else begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          if (req_stage == ADDR_STAGE_W'(s)) rdata_d = bank_rdata[s];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= SEQ_IDLE;
      rule_q         <= '0;
      commit_stage_q <= '0;
      commit_id_q    <= '0;
      err_cnt_q      <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q  <= state_d;
      rule_q   <= rule_d;
      rvalid_q <= accept && !i_cfg_wr;
      rdata_q  <= rdata_d;
      if (commit_go) begin
        commit_stage_q <= req_stage;
        commit_id_q    <= req_index;
      end
      if (accept && reject && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign o_cfg_rvalid     = rvalid_q;
  assign o_cfg_rdata      = rdata_q;
  assign o_rule_valid     = rule_q.valid;
  assign o_rule_typeData  = rule_q.type_data;
  assign o_rule_typeMask  = rule_q.type_mask;
  assign o_rule_keyOffset = rule_q.key_offset;
  assign o_err_cnt        = err_cnt_q;

endmodule
